// File: rtl/sint_diff_accum_if.sv
// Valid/ready bundle between the SInt subtract stage, the difference accumulator and its consumer.
// The master side drives samples and output-ready; the slave side is the accumulator.
interface sint_diff_accum_if #(
  parameter int WIDTH       = 3,
  parameter int ACC_WIDTH   = 8,
  parameter int COUNT_WIDTH = 4
) ();

  logic signed [WIDTH-1:0]     I;
  logic                        I_valid;
  logic                        I_ready;
  logic [COUNT_WIDTH-1:0]      N;
  logic signed [ACC_WIDTH-1:0] O;
  logic                        O_valid;
  logic                        O_ready;
  logic                        O_ovf;

  modport master (
    output I, I_valid, N, O_ready,
    input  I_ready, O, O_valid, O_ovf
  );

  modport slave (
    input  I, I_valid, N, O_ready,
    output I_ready, O, O_valid, O_ovf
  );

endinterface

// File: rtl/sint_diff_accum.sv
// Signed difference accumulator: sums max(N,1) sign-extended samples per frame and presents the total.
// Define SINT_DIFF_ACCUM_SAT_EN to saturate on overflow; otherwise the accumulator wraps.
module sint_diff_accum #(
  parameter int WIDTH       = 3,
  parameter int ACC_WIDTH   = 8,
  parameter int COUNT_WIDTH = 4
) (
  input  logic              CLK,
  input  logic              ASYNCRESETN,
  sint_diff_accum_if.slave  bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]                  state_q, state_d;
  logic signed [ACC_WIDTH-1:0] acc_q,   acc_d;
  logic [COUNT_WIDTH-1:0]      cnt_q,   cnt_d;
  logic [COUNT_WIDTH-1:0]      len_q,   len_d;
  logic                        ovf_q,   ovf_d;
  logic                        o_valid_q, o_valid_d;

  logic                        in_ready;
  logic                        accept;
  logic                        handshake;
  logic                        start_frame;
  logic [COUNT_WIDTH-1:0]      n_len;
  logic [COUNT_WIDTH-1:0]      cnt_inc;
  logic [ACC_WIDTH-1:0]        i_sext;
  logic [ACC_WIDTH:0]          sum_wide;
  logic                        add_ovf;
  logic [ACC_WIDTH-1:0]        add_res;

  // Ready is a pure function of state and downstream ready, held low while reset is asserted.
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ST_IDLE, ST_ACCUM: in_ready = 1'b1;
      ST_HOLD:           in_ready = bus.O_ready;
      default:           in_ready = 1'b0;
    endcase
    in_ready = in_ready & ASYNCRESETN;
  end

  assign accept    = bus.I_valid & in_ready;
  assign handshake = o_valid_q & bus.O_ready;

  // In HOLD an accept is only possible when O_ready is high, i.e. together with the handshake.
  assign start_frame = accept & ((state_q == ST_IDLE) | ((state_q == ST_HOLD) & handshake));

  assign n_len   = (bus.N == '0) ? COUNT_WIDTH'(1) : bus.N;
  assign cnt_inc = cnt_q + COUNT_WIDTH'(1);

  // One guard bit above the accumulator; a mismatch between the top two bits means overflow.
  assign i_sext   = {{(ACC_WIDTH-WIDTH){bus.I[WIDTH-1]}}, bus.I};
  assign sum_wide = {acc_q[ACC_WIDTH-1], acc_q} + {i_sext[ACC_WIDTH-1], i_sext};
  assign add_ovf  = sum_wide[ACC_WIDTH] ^ sum_wide[ACC_WIDTH-1];

`ifdef SINT_DIFF_ACCUM_SAT_EN
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  // The guard bit carries the sign of the true result, which picks the clamp direction.
  assign add_res = add_ovf ? (sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX)
                           : sum_wide[ACC_WIDTH-1:0];
`else
  assign add_res = sum_wide[ACC_WIDTH-1:0];
`endif

  // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    ovf_d   = ovf_q;

    if (start_frame) begin
      acc_d   = i_sext;
      cnt_d   = COUNT_WIDTH'(1);
      len_d   = n_len;
      ovf_d   = 1'b0;
      state_d = (n_len == COUNT_WIDTH'(1)) ? ST_HOLD : ST_ACCUM;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_ACCUM: begin
          if (accept) begin
            acc_d = add_res;
            ovf_d = ovf_q | add_ovf;
            cnt_d = cnt_inc;
            if (cnt_inc == len_q) begin
              state_d = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (handshake) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  assign o_valid_d = (state_d == ST_HOLD);

  // NOTE: state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state_q   <= ST_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= COUNT_WIDTH'(1);
      ovf_q     <= 1'b0;
      o_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      o_valid_q <= o_valid_d;
    end
  end

  assign bus.I_ready = in_ready;
  assign bus.O       = acc_q;
  assign bus.O_valid = o_valid_q;
  assign bus.O_ovf   = ovf_q;

endmodule

// File: tb/tb_sint_diff_accum.sv
// Directed and randomized bench for sint_diff_accum with a frame-level arithmetic reference model.
// The model follows SINT_DIFF_ACCUM_SAT_EN so the same bench covers both builds.
module tb_sint_diff_accum;

  localparam int W    = 3;
  localparam int AW   = 5;
  localparam int CW   = 4;
  localparam int MAXV = (1 << (AW - 1)) - 1;
  localparam int MINV = -(1 << (AW - 1));
  localparam int SPAN = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  sint_diff_accum_if #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) bus ();

  sint_diff_accum #(.WIDTH(W), .ACC_WIDTH(AW), .COUNT_WIDTH(CW)) dut (
    .CLK         (clk),
    .ASYNCRESETN (rst_n),
    .bus         (bus)
  );

  int total = 0;
  int bad   = 0;
  int smp[$];

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input bit v, input int i, input int n, input bit ordy);
    bus.I_valid = v;
    bus.I       = W'(i);
    bus.N       = CW'(n);
    bus.O_ready = ordy;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Frame total from plain integer arithmetic: overflow judged on every add.
  function automatic void model(output int sum, output int ov);
    int t;
    sum = smp[0];
    ov  = 0;
    for (int k = 1; k < smp.size(); k++) begin
      t = sum + smp[k];
      if (t > MAXV || t < MINV) ov = 1;
`ifdef SINT_DIFF_ACCUM_SAT_EN
      sum = (t > MAXV) ? MAXV : ((t < MINV) ? MINV : t);
`else
      sum = (t > MAXV) ? t - SPAN : ((t < MINV) ? t + SPAN : t);
`endif
    end
  endfunction

  // Feeds smp as one frame with frame length n; checks latency and the presented result.
  task automatic frame_in(input string tag, input int n, input int gap_pct, input bit ordy);
    int sum, ov;
    for (int k = 0; k < smp.size(); k++) begin
      while ($urandom_range(99) < gap_pct) begin
        drive(0, 0, $urandom_range(15), ordy);
        #1 check({tag, "_gap_ready"}, bus.I_ready, 1);
        step();
      end
      check({tag, "_pre_valid"}, bus.O_valid, 0);
      drive(1, smp[k], (k == 0) ? n : $urandom_range(15), ordy);
      #1 check({tag, "_in_ready"}, bus.I_ready, 1);
      step();
    end
    drive(0, 0, 0, 0);
    model(sum, ov);
    check({tag, "_valid"}, bus.O_valid, 1);
    check({tag, "_sum"},   bus.O, sum);
    check({tag, "_ovf"},   bus.O_ovf, ov);
  endtask

  // Stalls the consumer (with a sample offered) then takes the result with no new sample.
  task automatic drain(input string tag, input int stall, input int sum, input int ov);
    for (int k = 0; k < stall; k++) begin
      drive(1, 3, 1, 0);
      #1 check({tag, "_stall_ready"}, bus.I_ready, 0);
      check({tag, "_stall_valid"}, bus.O_valid, 1);
      check({tag, "_stall_sum"},   bus.O, sum);
      check({tag, "_stall_ovf"},   bus.O_ovf, ov);
      step();
    end
    drive(0, 0, 0, 1);
    #1 check({tag, "_take_ready"}, bus.I_ready, 1);
    step();
    check({tag, "_idle_valid"}, bus.O_valid, 0);
  endtask

  initial begin
    int n, len, sum, ov, prev, x;

    drive(0, 0, 0, 0);
    #12;
    check("rst_valid", bus.O_valid, 0);
    check("rst_o",     bus.O, 0);
    check("rst_ovf",   bus.O_ovf, 0);
    check("rst_ready", bus.I_ready, 0);
    step();
    rst_n = 1'b1;
    #1 check("post_rst_ready", bus.I_ready, 1);
    step();

    // Plain frame, no overflow.
    smp = '{3, 3, 3, 3, 3};
    frame_in("f5_pos", 5, 0, 1);
    check("f5_pos_exact", bus.O, 15);
    drain("f5_pos", 0, 15, 0);

    // Positive overflow.
    smp = '{3, 3, 3, 3, 3, 3};
    frame_in("f6_povf", 6, 0, 0);
`ifdef SINT_DIFF_ACCUM_SAT_EN
    check("f6_povf_exact", bus.O, 15);
`else
    check("f6_povf_exact", bus.O, -14);
`endif
    drain("f6_povf", 1, bus.O, 1);

    // Negative overflow.
    smp = '{-4, -4, -4, -4, -4};
    frame_in("f5_novf", 5, 0, 0);
`ifdef SINT_DIFF_ACCUM_SAT_EN
    check("f5_novf_exact", bus.O, -16);
`else
    check("f5_novf_exact", bus.O, 12);
`endif
    drain("f5_novf", 0, bus.O, 1);

    // Stalled result, then a new length-1 frame starting in the handshake cycle.
    smp = '{1, -2, 3};
    frame_in("f3_hold", 3, 0, 0);
    check("f3_hold_exact", bus.O, 2);
    for (int k = 0; k < 4; k++) begin
      drive(1, 3, 1, 0);
      #1 check("f3_hold_ready", bus.I_ready, 0);
      check("f3_hold_sum", bus.O, 2);
      step();
    end
    drive(1, -1, 1, 1);
    #1 check("handover_ready", bus.I_ready, 1);
    step();
    drive(0, 0, 0, 0);
    check("handover_valid", bus.O_valid, 1);
    check("handover_sum",   bus.O, -1);
    check("handover_ovf",   bus.O_ovf, 0);
    drain("handover", 0, -1, 0);

    // N=0 behaves as length 1.
    smp = '{-3};
    frame_in("n0", 0, 0, 0);
    check("n0_exact", bus.O, -3);
    drain("n0", 1, -3, 0);

    // Asynchronous reset mid-frame discards the partial sum.
    drive(1, 2, 4, 0);
    step();
    drive(1, 3, 4, 0);
    step();
    drive(0, 0, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.O_valid, 0);
    check("mid_rst_o",     bus.O, 0);
    check("mid_rst_ovf",   bus.O_ovf, 0);
    check("mid_rst_ready", bus.I_ready, 0);
    step();
    rst_n = 1'b1;
    #1 check("mid_rst_release_ready", bus.I_ready, 1);
    step();
    smp = '{1, 1};
    frame_in("after_rst", 2, 0, 0);
    check("after_rst_exact", bus.O, 2);
    drain("after_rst", 0, 2, 0);

    // Length-1 frames back to back: one result per cycle.
    prev = 0;
    for (int k = 0; k < 8; k++) begin
      x = int'($urandom_range(7)) - 4;
      drive(1, x, 1, 1);
      #1 check("b2b_ready", bus.I_ready, 1);
      step();
      check("b2b_valid", bus.O_valid, 1);
      check("b2b_sum",   bus.O, x);
      prev = x;
    end
    drive(0, 0, 0, 1);
    step();
    check("b2b_end_valid", bus.O_valid, 0);

    // Random frames with input bubbles and output stalls.
    for (int f = 0; f < 20; f++) begin
      n   = $urandom_range(0, 9);
      len = (n == 0) ? 1 : n;
      smp = {};
      for (int k = 0; k < len; k++) smp.push_back(int'($urandom_range(7)) - 4);
      frame_in("rnd", n, 25, 0);
      model(sum, ov);
      drain("rnd", $urandom_range(0, 3), sum, ov);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
